// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared state encoding and cell-mode constants for the ring-oscillator stress sequencer
package ro_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STRESS  = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    REPORT  = 3'd4
  } ro_state_e;

  localparam logic MODE_STATIC = 1'b1;
  localparam logic MODE_OSC    = 1'b0;

  localparam int SETTLE_CYC_DEFAULT = 16;

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - synchronizes the divided ring output and counts its rising edges, saturating
module ro_edge_counter #(
  parameter int CNT_W = 20
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             RingOut,
  input  logic             Clear,
  input  logic             Enable,
  output logic [CNT_W-1:0] Count,
  output logic             Ovf
);

  // [1:0] is the two-flop synchronizer, [2] is the previous synchronized level for edge detect
  logic [2:0] sync_q;
  logic       rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q <= '0;
      Count  <= '0;
      Ovf    <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], RingOut};
      if (Clear) begin
        Count <= '0;
        Ovf   <= 1'b0;
      end else if (Enable && rise) begin
        // An edge arriving at all-ones is lost; flag it and hold the count
        if (&Count) Ovf <= 1'b1;
        else        Count <= Count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_stress_sequencer.sv
// rtl/ro_stress_sequencer.sv - stress/settle/measure/report sequencer for one ring-oscillator cell
// Optional baseline measurement before the first stress window: RO_BASELINE_MEAS_EN
module ro_stress_sequencer
  import ro_pkg::*;
#(
  parameter int STRESS_W   = 32,
  parameter int GATE_W     = 24,
  parameter int CNT_W      = 20,
  parameter int ITER_W     = 8,
  parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                Abort,
  input  logic [STRESS_W-1:0] StressLen,
  input  logic [GATE_W-1:0]   GateLen,
  input  logic [ITER_W-1:0]   NumIter,
  input  logic                StressVal,
  input  logic                RingOut,
  output logic                Mode,
  output logic                Stress,
  output logic                Busy,
  output logic                Done,
  output logic [CNT_W-1:0]    MeasCount,
  output logic                MeasOvf,
  output logic                MeasValid,
  input  logic                MeasReady,
  output logic [ITER_W-1:0]   Iter
);

  localparam int TW = (STRESS_W > GATE_W) ? STRESS_W : GATE_W;

  ro_state_e           state, state_next;
  logic [TW-1:0]       timer;
  logic [STRESS_W-1:0] stress_len_q;
  logic [GATE_W-1:0]   gate_len_q;
  logic [ITER_W-1:0]   num_iter_q;
  logic                stress_val_q;

  logic                start_ok;
  logic                last_iter;
  logic [STRESS_W-1:0] stress_len_eff;
  logic                stress_val_eff;
  logic                stress_zero;
  logic                mode_d, stress_d, busy_d, done_d, valid_d;

  assign start_ok = (state == IDLE) && Start && !Abort;

  // Lengths are latched on the Start edge, so the IDLE exit must look at the live inputs
  assign stress_len_eff = (state == IDLE) ? StressLen : stress_len_q;
  assign stress_val_eff = (state == IDLE) ? StressVal : stress_val_q;
  assign stress_zero    = (stress_len_eff == '0);

`ifdef RO_BASELINE_MEAS_EN
  assign last_iter = (Iter == num_iter_q);
`else
  assign last_iter = (({1'b0, Iter} + {{ITER_W{1'b0}}, 1'b1}) == {1'b0, num_iter_q});
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef RO_BASELINE_MEAS_EN
          state_next = SETTLE;
`else
          state_next = stress_zero ? SETTLE : STRESS;
`endif
        end
      end
      STRESS:  if (timer == '0) state_next = SETTLE;
      SETTLE:  if (timer == '0) state_next = MEASURE;
      MEASURE: if (timer == '0) state_next = REPORT;
      REPORT: begin
        if (MeasReady) state_next = last_iter ? IDLE : (stress_zero ? SETTLE : STRESS);
      end
      default: state_next = IDLE;
    endcase
    if (Abort) state_next = IDLE;
  end

  // Output values are decoded from the next state and registered, so they line up with the state
  always_comb begin
    mode_d   = MODE_STATIC;
    stress_d = 1'b0;
    busy_d   = (state_next != IDLE);
    valid_d  = (state_next == REPORT);
    done_d   = (state == REPORT) && MeasReady && last_iter && !Abort;
    case (state_next)
      SETTLE, MEASURE: mode_d   = MODE_OSC;
      STRESS, REPORT:  stress_d = stress_val_eff;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Mode      <= MODE_STATIC;
      Stress    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      MeasValid <= 1'b0;
    end else begin
      Mode      <= mode_d;
      Stress    <= stress_d;
      Busy      <= busy_d;
      Done      <= done_d;
      MeasValid <= valid_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      timer        <= '0;
      stress_len_q <= '0;
      gate_len_q   <= '0;
      num_iter_q   <= '0;
      stress_val_q <= 1'b0;
      Iter         <= '0;
    end else begin
      if (start_ok) begin
        stress_len_q <= StressLen;
        gate_len_q   <= GateLen;
        num_iter_q   <= (NumIter == '0) ? ITER_W'(1) : NumIter;
        stress_val_q <= StressVal;
        Iter         <= '0;
      end else if ((state == REPORT) && MeasReady && !Abort) begin
        Iter <= Iter + ITER_W'(1);
      end

      // Every phase reloads its length on entry and runs down to zero
      if (state_next != state) begin
        case (state_next)
          STRESS:  timer <= TW'(stress_len_eff) - TW'(1);
          SETTLE:  timer <= TW'(SETTLE_CYC - 1);
          MEASURE: timer <= (gate_len_q == '0) ? '0 : TW'(gate_len_q) - TW'(1);
          default: timer <= '0;
        endcase
      end else if (timer != '0) begin
        timer <= timer - TW'(1);
      end
    end
  end

  ro_edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .Clk    (Clk),
    .Rst    (Rst),
    .RingOut(RingOut),
    .Clear  (state == SETTLE),
    .Enable (state == MEASURE),
    .Count  (MeasCount),
    .Ovf    (MeasOvf)
  );

endmodule

// File: tb/tb_ro_stress_sequencer.sv
// tb/tb_ro_stress_sequencer.sv - scoreboard bench for ro_stress_sequencer (default and RO_BASELINE_MEAS_EN builds)
module tb_ro_stress_sequencer;

`ifdef RO_BASELINE_MEAS_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, stress_val, meas_ready;
  logic        ring = 1'b0;
  logic [31:0] stress_len;
  logic [23:0] gate_len;
  logic [7:0]  num_iter;

  logic        mode, stress, busy, done, meas_ovf, meas_valid;
  logic [19:0] meas_count;
  logic [7:0]  iter;

  logic        s_mode, s_stress, s_busy, s_done, s_ovf, s_valid;
  logic [3:0]  s_count;
  logic [7:0]  s_iter;

  ro_stress_sequencer dut (
    .Clk(clk), .Rst(rst), .Start(start), .Abort(abort),
    .StressLen(stress_len), .GateLen(gate_len), .NumIter(num_iter), .StressVal(stress_val),
    .RingOut(ring), .Mode(mode), .Stress(stress), .Busy(busy), .Done(done),
    .MeasCount(meas_count), .MeasOvf(meas_ovf), .MeasValid(meas_valid),
    .MeasReady(meas_ready), .Iter(iter)
  );

  ro_stress_sequencer #(.CNT_W(4)) dut_sat (
    .Clk(clk), .Rst(rst), .Start(start), .Abort(abort),
    .StressLen(stress_len), .GateLen(gate_len), .NumIter(num_iter), .StressVal(stress_val),
    .RingOut(ring), .Mode(s_mode), .Stress(s_stress), .Busy(s_busy), .Done(s_done),
    .MeasCount(s_count), .MeasOvf(s_ovf), .MeasValid(s_valid),
    .MeasReady(meas_ready), .Iter(s_iter)
  );

  typedef struct {
    int iter;
    int lo;
    int hi;
    bit sat;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_pass = 0;
  longint cyc = 0;
  longint xfer_cyc = -1;
  int     done_cnt = 0;
  int     ring_half = 0;
  int     rcnt = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ring_half > 0) begin
      rcnt++;
      if (rcnt >= ring_half) begin
        rcnt = 0;
        ring = ~ring;
      end
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (done) done_cnt++;
    if (!rst && meas_valid && meas_ready) begin
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rep_iter", iter, e.iter);
        check("rep_count_in_range", (meas_count >= e.lo) && (meas_count <= e.hi), 1);
        if (e.sat) begin
          check("sat_count", s_count, 15);
          check("sat_ovf", s_ovf, 1);
          check("wide_ovf", meas_ovf, 0);
        end
      end
      xfer_cyc = cyc;
    end
  end

  task automatic start_run(input int slen, input int glen, input int niter, input bit sval,
                           input int half, input bit sat, input bit do_push);
    int n, p, lo, hi, g;
    stress_len = slen;
    gate_len   = glen;
    num_iter   = niter;
    stress_val = sval;
    ring_half  = half;
    rcnt       = 0;
    if (do_push) begin
      n  = ((niter == 0) ? 1 : niter) + BASE;
      g  = (glen == 0) ? 1 : glen;
      p  = 2 * half;
      lo = (p == 0) ? 0 : g / p;
      hi = (p == 0) ? 0 : (g + p - 1) / p;
      for (int i = 0; i < n; i++) sb.push_back('{iter: i, lo: lo, hi: hi, sat: sat});
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_level(input logic v, output int n);
    n = 0;
    while (mode === v && n < 10000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!meas_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid_seen"}, meas_valid, 1);
  endtask

  task automatic wait_osc(input string tag, input int budget);
    int k = 0;
    while (mode !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_osc_seen"}, mode, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_done_after_xfer"}, cyc - xfer_cyc, 1);
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, bad, d0;
    logic [19:0] held;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stress_val = 1'b0; meas_ready = 1'b1;
    stress_len = '0; gate_len = '0; num_iter = '0;
    repeat (3) @(negedge clk);
    check("rst_mode", mode, 1);
    check("rst_stress", stress, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", meas_count, 0);
    check("rst_ovf", meas_ovf, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_iter", iter, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run
    start_run(100, 50, 2, 1'b1, 4, 1'b0, 1'b1);
    check("t1_busy", busy, 1);
`ifndef RO_BASELINE_MEAS_EN
    check("t1_stress_lvl", stress, 1);
    count_level(1'b1, n);
    check("t1_stress_len", n, 100);
`else
    check("t6_no_pre_stress", mode, 0);
`endif
    count_level(1'b0, n);
    check("t1_osc_len", n, 66);
    wait_done("t1", 5000);
    check("t1_sb_empty", sb.size(), 0);

    // Backpressure, with a Start pulse that must be ignored while busy
    meas_ready = 1'b0;
    start_run(5, 20, 1, 1'b1, 3, 1'b0, 1'b1);
    wait_valid("t2", 2000);
    held = meas_count;
    bad  = 0;
    repeat (20) begin
      start = 1'b1;
      @(negedge clk);
      if (meas_valid !== 1'b1 || mode !== 1'b1 || stress !== 1'b1 || meas_count !== held) bad++;
    end
    start = 1'b0;
    check("t2_hold_bad_cycles", bad, 0);
    check("t2_no_advance", sb.size(), 1 + BASE);
    meas_ready = 1'b1;
    wait_done("t2", 3000);

    // Saturation on the narrow-counter instance
    start_run(10, 100, 1, 1'b1, 2, 1'b1, 1'b1);
    wait_done("t3", 3000);

    // Abort in MEASURE of the second report window
    start_run(10, 200, 3, 1'b1, 4, 1'b0, 1'b1);
    wait_valid("t4", 2000);
    @(negedge clk);
    wait_osc("t4", 200);
    repeat (40) @(negedge clk);
    check("t4_in_measure", mode, 0);
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t4_mode", mode, 1);
    check("t4_stress", stress, 0);
    check("t4_valid", meas_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_iter_held", iter, 1);
    repeat (10) @(negedge clk);
    check("t4_no_done", done_cnt - d0, 0);
    sb.delete();

    // Rst in MEASURE
    start_run(10, 200, 2, 1'b1, 4, 1'b0, 1'b0);
    wait_osc("t4r", 200);
    repeat (40) @(negedge clk);
    d0  = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t4r_mode", mode, 1);
    check("t4r_stress", stress, 0);
    check("t4r_valid", meas_valid, 0);
    check("t4r_busy", busy, 0);
    check("t4r_count", meas_count, 0);
    check("t4r_iter", iter, 0);
    repeat (5) @(negedge clk);
    check("t4r_no_done", done_cnt - d0, 0);

    // StressLen=0, NumIter=0, Start while busy in SETTLE
    start_run(0, 30, 0, 1'b0, 3, 1'b0, 1'b1);
    check("t5_zero_stress_skips", mode, 0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    count_level(1'b0, n);
    check("t5_osc_len_after_busy_start", n + 5, 46);
    wait_done("t5", 2000);
    check("t5_sb_empty", sb.size(), 0);

    // StressVal=0 during stress and report
    start_run(20, 10, 1, 1'b0, 3, 1'b0, 1'b1);
`ifndef RO_BASELINE_MEAS_EN
    check("t5_sv0_mode", mode, 1);
    check("t5_sv0_stress", stress, 0);
`endif
    wait_valid("t5b", 2000);
    check("t5_sv0_report_stress", stress, 0);
    wait_done("t5b", 2000);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
